// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one "1101" Mealy detector across NCH serial channels.
// Optional per-channel saturating hit counters are built when SEQ_SCHED_HITCNT_EN is defined.
module seq_detect_scheduler #(
   parameter int NCH  = 4,
   parameter int CNTW = 8
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic [NCH-1:0]      req,
   input  logic [NCH-1:0]      din,
   input  logic [NCH-1:0]      chclr,
   output logic [NCH-1:0]      ack,
   output logic [NCH-1:0]      hit,
   output logic [NCH*CNTW-1:0] hit_cnt
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_t;

   function automatic state_t next_state(input state_t s, input logic b);
      state_t n;
      case (s)
         S0:      n = b ? S1 : S0;
         S1:      n = b ? S2 : S0;
         S2:      n = b ? S2 : S3;
         S3:      n = b ? S1 : S0;
         default: n = S0;
      endcase
      return n;
   endfunction

   logic [PW-1:0]  ptr_reg;
   logic [NCH-1:0] elig;
   logic [PW-1:0]  cand;
   logic [PW-1:0]  grant_idx;
   logic           grant_vld;

   // A channel being cleared this cycle is never granted, so its bit stays pending.
   assign elig = (en && !clr) ? (req & ~chclr) : '0;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = PW'((int'(ptr_reg) + k) % NCH);
         if (!grant_vld && elig[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      ack = '0;
      if (grant_vld) ack[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ptr_reg <= '0;
      end else if (grant_vld) begin
         ptr_reg <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         state_t ctx_reg;
         logic   hit_reg;

         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               ctx_reg <= S0;
               hit_reg <= 1'b0;
            end else begin
               hit_reg <= ack[gi] && (ctx_reg == S3) && din[gi];
               if (chclr[gi]) begin
                  ctx_reg <= S0;
               end else if (ack[gi]) begin
                  ctx_reg <= next_state(ctx_reg, din[gi]);
               end
            end
         end

         assign hit[gi] = hit_reg;

`ifdef SEQ_SCHED_HITCNT_EN
         logic [CNTW-1:0] cnt_reg;

         // Counts registered hit pulses; a clear in the same cycle as a pulse wins.
         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               cnt_reg <= '0;
            end else if (chclr[gi]) begin
               cnt_reg <= '0;
            end else if (hit_reg && (cnt_reg != {CNTW{1'b1}})) begin
               cnt_reg <= cnt_reg + CNTW'(1);
            end
         end

         assign hit_cnt[gi*CNTW +: CNTW] = cnt_reg;
`else
         assign hit_cnt[gi*CNTW +: CNTW] = '0;
`endif
      end
   endgenerate

endmodule
